// File: rtl/slurm32_cpu_pkg.sv
// Shared definitions for the SLURM32 CPU pipeline blocks.
//  - Default parameter values for the hazard controller
//  - REG_BITS: width of a register select (matches decoder regA_sel/regB_sel)
//  - REG_ZERO: r0 select; r0 is hard-wired and never creates a hazard
//  - sb_entry_t: one scoreboard slot {valid, rd, load}
package slurm32_cpu_pkg;

    localparam int DEF_DEPTH     = 3;
    localparam int DEF_ALU_LAT   = 1;
    localparam int DEF_LOAD_SLOT = 2;
    localparam int DEF_CNT_BITS  = 16;
    localparam int REG_BITS      = 8;

    localparam logic [REG_BITS-1:0] REG_ZERO = '0;

    // rd is the in-flight destination register; load marks a memory load
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                load;
    } sb_entry_t;

endpackage

// File: rtl/slurm32_cpu_hazard_cmp.sv
// Combinational match of one source register select against every
// scoreboard slot.
//  src   in   REG_BITS  source select from the decoder
//  slots in   DEPTH     scoreboard slots (slot 0 = issued last cycle)
//  hit   out  1         src depends on a result that is not yet available
module slurm32_cpu_hazard_cmp
    import slurm32_cpu_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ALU_LAT   = DEF_ALU_LAT,
    parameter int LOAD_SLOT = DEF_LOAD_SLOT
) (
    input  logic [REG_BITS-1:0] src,
    input  sb_entry_t           slots [DEPTH],
    output logic                hit
);

    logic [DEPTH-1:0] slot_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        // Whether a result is still unavailable depends only on slot age,
        // so the window for ALU results and for loads is fixed per slot.
        localparam bit ALU_WIN  = (gi < ALU_LAT);
        localparam bit LOAD_WIN = (gi <= LOAD_SLOT);

        assign slot_hit[gi] = slots[gi].valid
                            & (slots[gi].rd == src)
                            & (slots[gi].load ? LOAD_WIN : ALU_WIN);
    end

    assign hit = (src != REG_ZERO) & (|slot_hit);

endmodule

// File: rtl/slurm32_cpu_hazard_ctrl.sv
// Pipeline interlock controller for the SLURM32 CPU.
// Tracks in-flight register writes in a DEPTH-slot scoreboard shift
// register, stalls dependent issue, freezes the pipe while a load waits
// for memory, and drops the youngest entry on a taken branch.
//  clk          in   1         core clock
//  rst          in   1         asynchronous active-high reset
//  issue_valid  in   1         instruction presented for issue
//  src_a/src_b  in   REG_BITS  source selects from the decoder
//  dst_reg      in   REG_BITS  destination of issuing instruction
//  dst_we       in   1         issuing instruction writes dst_reg
//  is_load      in   1         issuing instruction is a load
//  mem_ack      in   1         memory data returned for load in LOAD_SLOT
//  flush        in   1         branch taken: kill slot 0 and current issue
//  stall        out  1         hold fetch/decode
//  issue_ok     out  1         instruction enters slot 0 this edge
//  mem_wait     out  1         pipeline frozen waiting for mem_ack
//  stall_count  out  CNT_BITS  saturating count of stalled cycles
module slurm32_cpu_hazard_ctrl
    import slurm32_cpu_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ALU_LAT   = DEF_ALU_LAT,
    parameter int LOAD_SLOT = DEF_LOAD_SLOT,
    parameter int CNT_BITS  = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_BITS-1:0] src_a,
    input  logic [REG_BITS-1:0] src_b,
    input  logic [REG_BITS-1:0] dst_reg,
    input  logic                dst_we,
    input  logic                is_load,
    input  logic                mem_ack,
    input  logic                flush,
    output logic                stall,
    output logic                issue_ok,
    output logic                mem_wait,
    output logic [CNT_BITS-1:0] stall_count
);

    sb_entry_t           slot_reg  [DEPTH];
    sb_entry_t           slot_next [DEPTH];
    sb_entry_t           issue_entry;
    logic                hit_a;
    logic                hit_b;
    logic                hazard;
    logic [CNT_BITS-1:0] stall_count_reg;

    slurm32_cpu_hazard_cmp #(
        .DEPTH     (DEPTH),
        .ALU_LAT   (ALU_LAT),
        .LOAD_SLOT (LOAD_SLOT)
    ) u_cmp_a (
        .src   (src_a),
        .slots (slot_reg),
        .hit   (hit_a)
    );

    slurm32_cpu_hazard_cmp #(
        .DEPTH     (DEPTH),
        .ALU_LAT   (ALU_LAT),
        .LOAD_SLOT (LOAD_SLOT)
    ) u_cmp_b (
        .src   (src_b),
        .slots (slot_reg),
        .hit   (hit_b)
    );

    assign hazard   = issue_valid & (hit_a | hit_b);
    assign mem_wait = slot_reg[LOAD_SLOT].valid & slot_reg[LOAD_SLOT].load & ~mem_ack;
    assign stall    = mem_wait | hazard;
    assign issue_ok = issue_valid & ~stall & ~flush;

    // Writes to r0 are discarded by the register file, so they never
    // occupy a scoreboard slot.
    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = issue_ok & dst_we & (dst_reg != REG_ZERO);
        issue_entry.rd    = dst_reg;
        issue_entry.load  = is_load;
    end

    always_comb begin
        slot_next = slot_reg;
        if (mem_wait) begin
            // Frozen: everything holds, but a taken branch still kills
            // the youngest instruction.
            if (flush) begin
                slot_next[0].valid = 1'b0;
            end
        end else begin
            // issue_ok is already low on flush, so slot 0 gets a bubble.
            slot_next[0] = issue_entry;
            for (int k = 1; k < DEPTH; k++) begin
                slot_next[k] = slot_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= '0;
            end
        end else begin
            slot_reg <= slot_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_slurm32_cpu_hazard_ctrl.sv
module tb_slurm32_cpu_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, dst_we, is_load, mem_ack, flush;
    logic [7:0]  src_a, src_b, dst_reg;
    logic        stall, issue_ok, mem_wait;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slurm32_cpu_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .src_a       (src_a),
        .src_b       (src_b),
        .dst_reg     (dst_reg),
        .dst_we      (dst_we),
        .is_load     (is_load),
        .mem_ack     (mem_ack),
        .flush       (flush),
        .stall       (stall),
        .issue_ok    (issue_ok),
        .mem_wait    (mem_wait),
        .stall_count (stall_count)
    );

    // ---------------- reference model ----------------
    // In-flight writes kept as a queue ordered youngest-first; index = age.
    typedef struct {
        bit         v;
        logic [7:0] rd;
        bit         ld;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_cnt;
    bit          e_stall, e_ok, e_mw;

    function automatic void mdl_reset();
        ment_t e;
        e.v = 0; e.rd = 0; e.ld = 0;
        mq.delete();
        repeat (3) mq.push_back(e);
        m_cnt = 0;
    endfunction

    // A result is unavailable for age < 1 (ALU) or age <= 2 (load).
    function automatic bit mdl_hit(logic [7:0] s);
        if (s == 0) return 0;
        for (int age = 0; age < mq.size(); age++) begin
            if (mq[age].v && mq[age].rd == s) begin
                if (!mq[age].ld && age < 1) return 1;
                if (mq[age].ld && age <= 2) return 1;
            end
        end
        return 0;
    endfunction

    function automatic void mdl_eval();
        bit haz;
        e_mw    = mq[2].v && mq[2].ld && !mem_ack;
        haz     = issue_valid && (mdl_hit(src_a) || mdl_hit(src_b));
        e_stall = e_mw || haz;
        e_ok    = issue_valid && !e_stall && !flush;
    endfunction

    function automatic void mdl_edge();
        ment_t e;
        if (e_stall && m_cnt < 32'hFFFF) m_cnt++;
        if (e_mw) begin
            if (flush) begin
                e = mq[0]; e.v = 0; mq[0] = e;
            end
        end else begin
            void'(mq.pop_back());
            e.v  = e_ok && dst_we && (dst_reg != 0);
            e.rd = dst_reg;
            e.ld = is_load;
            mq.push_front(e);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit iv, input logic [7:0] sa, input logic [7:0] sb,
                          input logic [7:0] d, input bit we, input bit ld,
                          input bit ack, input bit fl);
        @(negedge clk);
        issue_valid = iv; src_a = sa; src_b = sb; dst_reg = d;
        dst_we = we; is_load = ld; mem_ack = ack; flush = fl;
        #1;
        mdl_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++; if (stall !== 1'b0)       begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (issue_ok !== 1'b0)    begin n_bad++; $display("FAIL reset_issue_ok: got %b want 0", issue_ok); end
        n_cmp++; if (mem_wait !== 1'b0)    begin n_bad++; $display("FAIL reset_mem_wait: got %b want 0", mem_wait); end
        n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0h want 0", stall_count); end
        // load r7, then two independent ALU ops so the load reaches slot 2
        set_in(1, 0, 0, 8'd7, 1, 1, 1, 0); tick();
        set_in(1, 1, 2, 8'd9, 1, 0, 1, 0); tick();
        set_in(1, 1, 2, 8'd8, 1, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (mem_wait !== e_mw) begin n_bad++; $display("FAIL pre_reset_mem_wait: got %b want %b", mem_wait, e_mw); end
        #2 rst = 1'b1;
        #1;
        mdl_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dut.slot_reg[k].valid !== 1'b0) begin n_bad++; $display("FAIL reset_slot%0d_valid: got %b want 0", k, dut.slot_reg[k].valid); end
        end
        n_cmp++; if (mem_wait !== 1'b0) begin n_bad++; $display("FAIL reset_async_mem_wait: got %b want 0", mem_wait); end
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (stall !== 1'b0)        begin n_bad++; $display("FAIL post_reset_stall: got %b want 0", stall); end
        n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL post_reset_count: got %0h want 0", stall_count); end
        $display("test_reset done");
    endtask

    task automatic test_alu_pair();
        int cyc = 0;
        idle(3);
        set_in(1, 8'd4, 8'd5, 8'd3, 1, 0, 1, 0);   // add r3,r4,r5
        n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL alu_first_issue: got %b want 1", issue_ok); end
        tick();
        while (cyc < 10) begin                      // add r6,r3,r0
            set_in(1, 8'd3, 8'd0, 8'd6, 1, 0, 1, 0);
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL alu_stall cyc%0d: got %b want %b", cyc, stall, e_stall); end
            if (issue_ok) break;
            cyc++;
            tick();
            if (cyc == 1) begin
                n_cmp++; if (dut.slot_reg[0].valid !== 1'b0) begin n_bad++; $display("FAIL alu_bubble: got %b want 0", dut.slot_reg[0].valid); end
            end
        end
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL alu_stall_cycles: got %0d want 1", cyc); end
        tick();
        $display("test_alu_pair: stalled %0d cycle(s)", cyc);
    endtask

    task automatic test_load_pair();
        int cyc = 0;
        idle(3);
        set_in(1, 0, 0, 8'd7, 1, 1, 1, 0); tick();  // ld r7
        while (cyc < 10) begin                      // ba [r7,0x10]
            set_in(1, 8'd7, 8'd0, 8'd0, 0, 0, 1, 0);
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL load_stall cyc%0d: got %b want %b", cyc, stall, e_stall); end
            if (issue_ok) break;
            cyc++;
            tick();
        end
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL load_stall_cycles: got %0d want 3", cyc); end
        tick();
        $display("test_load_pair: stalled %0d cycle(s)", cyc);
    endtask

    task automatic test_mem_wait();
        int unsigned cnt_start;
        idle(3);
        set_in(1, 0, 0, 8'd10, 1, 1, 1, 0); tick();   // ld r10
        set_in(1, 1, 2, 8'd11, 1, 0, 1, 0); tick();
        set_in(1, 1, 2, 8'd12, 1, 0, 1, 0); tick();
        cnt_start = m_cnt;
        for (int i = 0; i < 4; i++) begin
            // first frozen cycle also carries a taken branch
            set_in(1, 1, 2, 8'd13, 1, 0, 0, (i == 0));
            n_cmp++; if (mem_wait !== 1'b1) begin n_bad++; $display("FAIL freeze_mem_wait cyc%0d: got %b want 1", i, mem_wait); end
            n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL freeze_issue_ok cyc%0d: got %b want 0", i, issue_ok); end
            tick();
            n_cmp++; if (dut.slot_reg[2].rd !== 8'd10 || dut.slot_reg[1].rd !== 8'd11) begin
                n_bad++; $display("FAIL freeze_slots cyc%0d: got s2=%0d s1=%0d want 10 11", i, dut.slot_reg[2].rd, dut.slot_reg[1].rd);
            end
            n_cmp++; if (dut.slot_reg[0].valid !== 1'b0) begin n_bad++; $display("FAIL freeze_flush_slot0 cyc%0d: got %b want 0", i, dut.slot_reg[0].valid); end
        end
        n_cmp++; if (stall_count !== 16'(cnt_start + 4)) begin n_bad++; $display("FAIL freeze_count: got %0d want %0d", stall_count, cnt_start + 4); end
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (mem_wait !== 1'b0) begin n_bad++; $display("FAIL freeze_release: got %b want 0", mem_wait); end
        tick();
        n_cmp++; if (dut.slot_reg[2].rd !== 8'd11 || dut.slot_reg[2].valid !== 1'b1) begin
            n_bad++; $display("FAIL resume_shift: got s2 v=%b rd=%0d want v=1 rd=11", dut.slot_reg[2].valid, dut.slot_reg[2].rd);
        end
        $display("test_mem_wait: count %0d -> %0d", cnt_start, stall_count);
    endtask

    task automatic test_flush();
        idle(3);
        set_in(1, 8'd4, 8'd5, 8'd3, 1, 0, 1, 0); tick();
        set_in(1, 8'd3, 8'd0, 8'd6, 1, 0, 1, 1);    // dependent + flush
        n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL flush_issue_ok: got %b want 0", issue_ok); end
        n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL flush_stall: got %b want %b", stall, e_stall); end
        tick();
        n_cmp++; if (dut.slot_reg[0].valid !== 1'b0) begin n_bad++; $display("FAIL flush_slot0: got %b want 0", dut.slot_reg[0].valid); end
        n_cmp++; if (dut.slot_reg[1].valid !== 1'b1 || dut.slot_reg[1].rd !== 8'd3) begin
            n_bad++; $display("FAIL flush_slot1: got v=%b rd=%0d want v=1 rd=3", dut.slot_reg[1].valid, dut.slot_reg[1].rd);
        end
        $display("test_flush done");
    endtask

    task automatic test_r0();
        idle(3);
        set_in(1, 1, 2, 8'd0, 1, 0, 1, 0); tick();  // write to r0
        set_in(1, 8'd0, 8'd3, 8'd4, 1, 0, 1, 0);    // asr, src_a=0 src_b=3
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL r0_stall: got %b want 0", stall); end
        n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL r0_issue_ok: got %b want 1", issue_ok); end
        tick();
        $display("test_r0 done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                   8'($urandom_range(0, 3)), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
            n_cmp++; if (stall !== e_stall)       begin n_bad++; $display("FAIL rnd_stall cyc%0d: got %b want %b", i, stall, e_stall); end
            n_cmp++; if (issue_ok !== e_ok)       begin n_bad++; $display("FAIL rnd_issue_ok cyc%0d: got %b want %b", i, issue_ok, e_ok); end
            n_cmp++; if (mem_wait !== e_mw)       begin n_bad++; $display("FAIL rnd_mem_wait cyc%0d: got %b want %b", i, mem_wait, e_mw); end
            n_cmp++; if (stall_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", i, stall_count, m_cnt); end
            if (e_ok) $display("issue cyc%0d a=%0d b=%0d d=%0d we=%b ld=%b", i, src_a, src_b, dst_reg, dst_we, is_load);
            tick();
        end
    endtask

    task automatic test_saturate();
        idle(3);
        set_in(1, 0, 0, 8'd20, 1, 1, 1, 0); tick();
        idle(2);
        for (int i = 0; i < 65540; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (stall_count !== 16'hFFFF)   begin n_bad++; $display("FAIL sat_count: got %0h want ffff", stall_count); end
        n_cmp++; if (stall_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL sat_model: got %0h want %0h", stall_count, m_cnt); end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (stall_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %0h want ffff", stall_count); end
        tick();
        $display("test_saturate: count %0h", stall_count);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 0; src_a = 0; src_b = 0; dst_reg = 0;
        dst_we = 0; is_load = 0; mem_ack = 1; flush = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        #1;
        test_reset();
        test_alu_pair();
        test_load_pair();
        test_mem_wait();
        test_flush();
        test_r0();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
